// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Zero-latency lookup for IF, combinational resolve check and single-entry training for EX.
module branch_predictor_btb #(
   parameter int ENTRIES = 64,
   parameter int TAG_W   = 10,
   parameter int CTR_W   = 2,
   parameter int CNT_W   = 32
) (
   input  logic              cpu_clk,
   input  logic              cpu_rst,
   input  logic [31:0]       pred_pc,
   output logic              pred_hit,
   output logic              pred_taken,
   output logic [31:0]       pred_npc,
   input  logic              upd_valid,
   input  logic [31:0]       upd_pc,
   input  logic              upd_is_jump,
   input  logic              upd_taken,
   input  logic [31:0]       upd_target,
   input  logic              upd_pred_taken,
   input  logic [31:0]       upd_pred_npc,
   output logic              mispredict,
   output logic [31:0]       redirect_pc,
   input  logic              bp_clear,
   output logic [CNT_W-1:0]  stat_updates,
   output logic [CNT_W-1:0]  stat_mispred
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
   localparam logic [CTR_W-1:0] CTR_WT  = {1'b1, {(CTR_W-1){1'b0}}};
   localparam logic [CTR_W-1:0] CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};

   logic              valid_reg  [ENTRIES];
   logic [TAG_W-1:0]  tag_reg    [ENTRIES];
   logic [31:0]       target_reg [ENTRIES];
   logic [CTR_W-1:0]  ctr_reg    [ENTRIES];

   logic [IDX_W-1:0]  pred_idx;
   logic [IDX_W-1:0]  upd_idx;
   logic [TAG_W-1:0]  pred_tag;
   logic [TAG_W-1:0]  upd_tag;
   logic              upd_hit;
   logic [CTR_W-1:0]  upd_ctr;
   logic [CTR_W-1:0]  ctr_next;
   logic              entry_we;
   logic              target_we;
   logic [ENTRIES-1:0] entry_sel;
   logic              upd_pred_unused;

   assign pred_idx = pred_pc[IDX_W+1:2];
   assign pred_tag = pred_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign upd_idx  = upd_pc[IDX_W+1:2];
   assign upd_tag  = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

   // The carried predicted direction is redundant with upd_pred_npc for all decisions here.
   assign upd_pred_unused = upd_pred_taken;

   assign pred_hit   = valid_reg[pred_idx] && (tag_reg[pred_idx] == pred_tag);
   assign pred_taken = pred_hit && ctr_reg[pred_idx][CTR_W-1];
   assign pred_npc   = pred_taken ? target_reg[pred_idx] : pred_pc + 32'd4;

   assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;
   assign mispredict  = upd_valid && (redirect_pc != upd_pred_npc);

   assign upd_hit = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);
   assign upd_ctr = ctr_reg[upd_idx];

   always_comb begin
      ctr_next  = upd_ctr;
      entry_we  = 1'b0;
      target_we = 1'b0;
      if (upd_valid && !bp_clear) begin
         if (upd_hit) begin
            entry_we = 1'b1;
            if (upd_is_jump) begin
               ctr_next  = CTR_MAX;
               target_we = 1'b1;
            end else if (upd_taken) begin
               ctr_next  = (upd_ctr == CTR_MAX) ? CTR_MAX : upd_ctr + CTR_W'(1);
               target_we = 1'b1;
            end else begin
               ctr_next = (upd_ctr == '0) ? '0 : upd_ctr - CTR_W'(1);
            end
         end else if (upd_taken) begin
            // Miss on a taken branch: allocate, evicting whatever shares the index.
            entry_we  = 1'b1;
            target_we = 1'b1;
            ctr_next  = upd_is_jump ? CTR_MAX : CTR_WT;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_sel
         localparam logic [IDX_W-1:0] GI_IDX = IDX_W'(gi);
         assign entry_sel[gi] = entry_we && (upd_idx == GI_IDX);
      end
   endgenerate

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_reg[i]  <= 1'b0;
            tag_reg[i]    <= '0;
            target_reg[i] <= '0;
            ctr_reg[i]    <= CTR_WNT;
         end
      end else if (bp_clear) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_reg[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (entry_sel[i]) begin
               valid_reg[i] <= 1'b1;
               tag_reg[i]   <= upd_tag;
               ctr_reg[i]   <= ctr_next;
               if (target_we) begin
                  target_reg[i] <= upd_target;
               end
            end
         end
      end
   end

   // Statistics keep counting across bp_clear, including a dropped update.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         stat_updates <= '0;
         stat_mispred <= '0;
      end else begin
         if (upd_valid) begin
            stat_updates <= stat_updates + CNT_W'(1);
         end
         if (mispredict) begin
            stat_mispred <= stat_mispred + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a table-level behavioural model.
module tb_branch_predictor_btb;

   localparam int ENTRIES = 64;
   localparam int TAG_W   = 10;
   localparam int CTR_W   = 2;
   localparam int CNT_W   = 4;
   localparam int CMAX    = (1 << CTR_W) - 1;
   localparam int CHALF   = 1 << (CTR_W - 1);
   localparam int CNT_MOD = 1 << CNT_W;

   logic              cpu_clk;
   logic              cpu_rst;
   logic [31:0]       pred_pc;
   logic              pred_hit;
   logic              pred_taken;
   logic [31:0]       pred_npc;
   logic              upd_valid;
   logic [31:0]       upd_pc;
   logic              upd_is_jump;
   logic              upd_taken;
   logic [31:0]       upd_target;
   logic              upd_pred_taken;
   logic [31:0]       upd_pred_npc;
   logic              mispredict;
   logic [31:0]       redirect_pc;
   logic              bp_clear;
   logic [CNT_W-1:0]  stat_updates;
   logic [CNT_W-1:0]  stat_mispred;

   branch_predictor_btb #(
      .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CTR_W(CTR_W), .CNT_W(CNT_W)
   ) dut (
      .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
      .pred_pc(pred_pc), .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_npc(pred_npc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .upd_pred_npc(upd_pred_npc),
      .mispredict(mispredict), .redirect_pc(redirect_pc), .bp_clear(bp_clear),
      .stat_updates(stat_updates), .stat_mispred(stat_mispred)
   );

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   int tests = 0;
   int fails = 0;
   bit chk_en = 0;
   bit verbose = 1;

   // Behavioural model: one record per table slot, counters as plain integers.
   bit          m_v   [ENTRIES];
   int unsigned m_tag [ENTRIES];
   logic [31:0] m_tgt [ENTRIES];
   int          m_ctr [ENTRIES];
   int unsigned m_stu;
   int unsigned m_stm;

   function automatic int unsigned f_idx(input logic [31:0] pc);
      return (pc / 4) % ENTRIES;
   endfunction

   function automatic int unsigned f_tag(input logic [31:0] pc);
      return (pc / (4 * ENTRIES)) % (1 << TAG_W);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 32'h0; m_ctr[i] = CHALF - 1;
      end
      m_stu = 0; m_stm = 0;
   endtask

   task automatic model_predict(input logic [31:0] pc, output bit hit, output bit tk,
                                output logic [31:0] npc);
      int unsigned i;
      i   = f_idx(pc);
      hit = m_v[i] && (m_tag[i] == f_tag(pc));
      tk  = hit && (m_ctr[i] >= CHALF);
      npc = tk ? m_tgt[i] : pc + 32'd4;
   endtask

   function automatic logic [31:0] model_redirect();
      return upd_taken ? upd_target : upd_pc + 32'd4;
   endfunction

   function automatic bit model_mispred();
      return upd_valid && (model_redirect() != upd_pred_npc);
   endfunction

   task automatic model_update();
      int unsigned i;
      bit hit;
      i   = f_idx(upd_pc);
      hit = m_v[i] && (m_tag[i] == f_tag(upd_pc));
      if (upd_valid) m_stu = (m_stu + 1) % CNT_MOD;
      if (model_mispred()) m_stm = (m_stm + 1) % CNT_MOD;
      if (bp_clear) begin
         for (int k = 0; k < ENTRIES; k++) m_v[k] = 0;
      end else if (upd_valid) begin
         if (hit && upd_is_jump) begin
            m_ctr[i] = CMAX; m_tgt[i] = upd_target;
         end else if (hit && upd_taken) begin
            m_ctr[i] = (m_ctr[i] + 1 > CMAX) ? CMAX : m_ctr[i] + 1; m_tgt[i] = upd_target;
         end else if (hit) begin
            m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
         end else if (upd_taken) begin
            m_v[i] = 1; m_tag[i] = f_tag(upd_pc); m_tgt[i] = upd_target;
            m_ctr[i] = upd_is_jump ? CMAX : CHALF;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, mid-way through the low clock phase.
   always begin
      bit          e_hit;
      bit          e_tk;
      logic [31:0] e_npc;
      @(negedge cpu_clk);
      #2;
      if (chk_en) begin
         model_predict(pred_pc, e_hit, e_tk, e_npc);
         check("pred_hit", {31'b0, pred_hit}, {31'b0, e_hit});
         check("pred_taken", {31'b0, pred_taken}, {31'b0, e_tk});
         check("pred_npc", pred_npc, e_npc);
         check("mispredict", {31'b0, mispredict}, {31'b0, model_mispred()});
         check("redirect_pc", redirect_pc, model_redirect());
         check("stat_updates", 32'(stat_updates), m_stu);
         check("stat_mispred", 32'(stat_mispred), m_stm);
      end
   end

   task automatic set_upd(input bit v, input logic [31:0] pc, input bit jump, input bit tk,
                          input logic [31:0] tgt, input logic [31:0] pnpc);
      upd_valid = v; upd_pc = pc; upd_is_jump = jump; upd_taken = tk;
      upd_target = tgt; upd_pred_npc = pnpc; upd_pred_taken = (pnpc != pc + 32'd4);
   endtask

   task automatic idle();
      set_upd(0, 32'h0, 0, 0, 32'h0, 32'h4);
   endtask

   task automatic tick();
      @(posedge cpu_clk);
      if (verbose)
         $display("[TB] pred_pc=%h hit=%0b npc=%h | upd v=%0b pc=%h j=%0b t=%0b clr=%0b mis=%0b redir=%h",
                  pred_pc, pred_hit, pred_npc, upd_valid, upd_pc, upd_is_jump, upd_taken,
                  bp_clear, mispredict, redirect_pc);
      if (!cpu_rst) model_update();
      @(negedge cpu_clk);
   endtask

   function automatic logic [31:0] rand_pc();
      return 32'h00400000 | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 2) << 8);
   endfunction

   initial begin
      bit          r_hit;
      bit          r_tk;
      logic [31:0] r_npc;
      int unsigned saved;
      cpu_rst = 1'b1; bp_clear = 1'b0; pred_pc = 32'h0; idle(); model_reset();
      repeat (2) @(negedge cpu_clk);
      cpu_rst = 1'b0; chk_en = 1;

      // Reset state
      pred_pc = 32'h00400000; #1;
      check("rst_hit", {31'b0, pred_hit}, 32'h0);
      check("rst_taken", {31'b0, pred_taken}, 32'h0);
      check("rst_npc", pred_npc, 32'h00400004);
      check("rst_stat_upd", 32'(stat_updates), 32'h0);
      check("rst_stat_mis", 32'(stat_mispred), 32'h0);
      tick();

      // Branch training and down-saturation
      set_upd(1, 32'h00400010, 0, 1, 32'h00400040, 32'h00400014); #1;
      check("alloc_mis", {31'b0, mispredict}, 32'h1);
      check("alloc_redir", redirect_pc, 32'h00400040);
      tick();
      idle(); pred_pc = 32'h00400010; #1;
      check("trained_hit", {31'b0, pred_hit}, 32'h1);
      check("trained_taken", {31'b0, pred_taken}, 32'h1);
      check("trained_npc", pred_npc, 32'h00400040);
      tick();
      set_upd(1, 32'h00400010, 0, 0, 32'h00400040, 32'h00400040); #1;
      check("nt1_redir", redirect_pc, 32'h00400014);
      check("nt1_mis", {31'b0, mispredict}, 32'h1);
      tick();
      set_upd(1, 32'h00400010, 0, 0, 32'h00400040, 32'h00400014); tick();
      idle(); #1;
      check("ctr0_taken", {31'b0, pred_taken}, 32'h0);
      check("ctr0_npc", pred_npc, 32'h00400014);
      tick();
      set_upd(1, 32'h00400010, 0, 0, 32'h00400040, 32'h00400014); #1;
      check("nt3_mis", {31'b0, mispredict}, 32'h0);
      tick();
      set_upd(1, 32'h00400010, 0, 1, 32'h00400040, 32'h00400014); tick();
      idle(); #1;
      check("sat0_taken", {31'b0, pred_taken}, 32'h0);
      check("stat_upd5", 32'(stat_updates), 32'd5);
      check("stat_mis3", 32'(stat_mispred), 32'd3);
      tick();

      // jal: strongly taken after a single update
      pred_pc = 32'h00400100;
      set_upd(1, 32'h00400100, 1, 1, 32'h00400200, 32'h00400104); #1;
      check("jal_mis", {31'b0, mispredict}, 32'h1);
      tick();
      idle(); #1;
      check("jal_npc", pred_npc, 32'h00400200);
      tick();
      for (int i = 0; i < 3; i++) begin
         set_upd(1, 32'h00400100, 0, 1, 32'h00400200, 32'h00400200); #1;
         check("jal_ok_mis", {31'b0, mispredict}, 32'h0);
         tick();
      end
      set_upd(1, 32'h00400100, 0, 0, 32'h00400200, 32'h00400200); tick();
      idle(); #1;
      check("jal_still_taken", {31'b0, pred_taken}, 32'h1);
      tick();

      // Alias eviction at the same index
      set_upd(1, 32'h00400110, 0, 1, 32'h00400300, 32'h00400114); tick();
      idle(); pred_pc = 32'h00400010; #1;
      check("evicted_hit", {31'b0, pred_hit}, 32'h0);
      check("evicted_npc", pred_npc, 32'h00400014);
      tick();
      pred_pc = 32'h00400110; #1;
      check("alias_npc", pred_npc, 32'h00400300);
      tick();

      // Same-cycle lookup and update: no bypass
      set_upd(1, 32'h00400110, 0, 0, 32'h0, 32'h00400300); #1;
      check("nobyp_taken", {31'b0, pred_taken}, 32'h1);
      check("nobyp_npc", pred_npc, 32'h00400300);
      tick();
      idle(); #1;
      check("after_byp_taken", {31'b0, pred_taken}, 32'h0);
      check("after_byp_npc", pred_npc, 32'h00400114);
      tick();

      // bp_clear beats a same-cycle update, which still counts
      saved = m_stu;
      pred_pc = 32'h00400100; bp_clear = 1'b1;
      set_upd(1, 32'h00400100, 1, 1, 32'h00400200, 32'h00400200); #1;
      check("preclr_hit", {31'b0, pred_hit}, 32'h1);
      tick();
      bp_clear = 1'b0; idle(); #1;
      check("clr_hit", {31'b0, pred_hit}, 32'h0);
      check("clr_stat_upd", 32'(stat_updates), (saved + 1) % CNT_MOD);
      tick();
      pred_pc = 32'h00400110; #1;
      check("clr_hit2", {31'b0, pred_hit}, 32'h0);
      tick();

      // Asynchronous reset between edges
      set_upd(1, 32'h00400010, 0, 1, 32'h00400040, 32'h00400014); tick();
      idle(); pred_pc = 32'h00400010; #1;
      check("pre_rst_hit", {31'b0, pred_hit}, 32'h1);
      #2;
      cpu_rst = 1'b1; model_reset(); #1;
      check("async_rst_hit", {31'b0, pred_hit}, 32'h0);
      check("async_rst_npc", pred_npc, 32'h00400014);
      check("async_rst_stu", 32'(stat_updates), 32'h0);
      @(posedge cpu_clk);
      @(negedge cpu_clk);
      cpu_rst = 1'b0; #1;
      check("post_rst_hit", {31'b0, pred_hit}, 32'h0);
      tick();

      // Statistics wrap
      pred_pc = 32'h00400000;
      for (int i = 0; i < 16; i++) begin
         set_upd(1, 32'h00400020, 0, 0, 32'h0, 32'h0); #1;
         if (i == 15) check("stat_mis_max", 32'(stat_mispred), CNT_MOD - 1);
         tick();
      end
      idle(); #1;
      check("stat_mis_wrap", 32'(stat_mispred), 32'h0);
      check("stat_upd_wrap", 32'(stat_updates), 32'h0);
      tick();

      // Randomized traffic
      verbose = 0;
      repeat (3000) begin
         logic [31:0] pc;
         bit          jmp;
         pc  = rand_pc();
         jmp = ($urandom_range(0, 7) == 0);
         model_predict(pc, r_hit, r_tk, r_npc);
         set_upd($urandom_range(0, 3) != 0, pc, jmp, jmp || ($urandom_range(0, 1) == 1),
                 rand_pc(), ($urandom_range(0, 3) != 0) ? r_npc : rand_pc());
         pred_pc  = ($urandom_range(0, 3) == 0) ? pc : rand_pc();
         bp_clear = ($urandom_range(0, 40) == 0);
         tick();
      end
      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
